// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller: scoreboard
// entry layout, register-zero constant and the forward-select width.
package hazard_pkg;

  // Register fields are stored at a fixed maximum width; narrower REG_AW
  // values are zero-extended on entry so one struct serves every build.
  localparam int unsigned REG_AW_MAX = 8;

  typedef logic [REG_AW_MAX-1:0] reg_t;

  localparam reg_t REG_ZERO = '0;

  typedef struct packed {
    logic valid;
    reg_t rd;
    logic regwrite;
    logic memread;
  } sb_entry_t;

  // Source operands of the instruction currently in EX (entry 0 only).
  typedef struct packed {
    reg_t rs;
    reg_t rt;
    logic rs_used;
    logic rt_used;
  } ex_src_t;

  function automatic int unsigned fwd_sel_w(input int unsigned stages);
    return (stages < 2) ? 1 : $clog2(stages);
  endfunction

  // Register 0 is hard-wired, so a write to it never produces a value.
  function automatic logic is_producer(input sb_entry_t e);
    return e.valid && e.regwrite && (e.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_fwd_pick.sv
// Forward-source search for one EX operand: picks the youngest downstream
// stage (lowest index) holding a forwardable result for the operand.
module hazard_fwd_pick
  import hazard_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = fwd_sel_w(STAGES)
) (
  input  logic                    ex_valid_i,
  input  reg_t                    src_i,
  input  logic                    src_used_i,
  input  sb_entry_t [STAGES-1:1]  sb_i,
  output logic [SEL_W-1:0]        sel_o
);

  // Scanning from the oldest stage toward the youngest lets the youngest
  // matching producer overwrite any older one.
  always_comb begin
    sel_o = '0;
    if (ex_valid_i && src_used_i && (src_i != REG_ZERO)) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        if (is_producer(sb_i[k]) && (sb_i[k].rd == src_i) &&
            (!sb_i[k].memread || (k >= LOAD_LAT))) begin
          sel_o = SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall/bubble, ID redirect flush and
// EX operand forward selection. Define HAZARD_PERF_EN for stall/flush counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          id_valid_i,
  input  logic [REG_AW-1:0]             id_rs_i,
  input  logic [REG_AW-1:0]             id_rt_i,
  input  logic                          id_rs_used_i,
  input  logic                          id_rt_used_i,
  input  logic [REG_AW-1:0]             id_rd_i,
  input  logic                          id_regwrite_i,
  input  logic                          id_memread_i,
  input  logic                          branch_taken_i,
  input  logic                          jump_i,
  output logic                          stall_o,
  output logic                          bubble_o,
  output logic                          flush_ifid_o,
  output logic [fwd_sel_w(STAGES)-1:0]  fwd_rs_sel_o,
  output logic [fwd_sel_w(STAGES)-1:0]  fwd_rt_sel_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                   stall_cnt_o,
  output logic [31:0]                   flush_cnt_o
`endif
);

  localparam int SEL_W = fwd_sel_w(STAGES);

  sb_entry_t [STAGES-1:0] sb_q, sb_d;
  ex_src_t                ex_q, ex_d;

  reg_t                   id_rs_ext, id_rt_ext, id_rd_ext;
  logic                   load_use_hit;
  logic                   stall;
  logic                   flush;
  logic [SEL_W-1:0]       rs_sel, rt_sel;

  assign id_rs_ext = reg_t'(id_rs_i);
  assign id_rt_ext = reg_t'(id_rt_i);
  assign id_rd_ext = reg_t'(id_rd_i);

  // A load at stage k reaches stage k+1 when the ID instruction enters EX;
  // if that is still short of LOAD_LAT its result cannot be forwarded yet.
  always_comb begin
    load_use_hit = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if ((k + 1 < LOAD_LAT) && is_producer(sb_q[k]) && sb_q[k].memread) begin
        if (id_rs_used_i && (id_rs_ext == sb_q[k].rd)) begin
          load_use_hit = 1'b1;
        end
        if (id_rt_used_i && (id_rt_ext == sb_q[k].rd)) begin
          load_use_hit = 1'b1;
        end
      end
    end
  end

  assign stall = ~rst_i & id_valid_i & load_use_hit;
  assign flush = ~rst_i & id_valid_i & (branch_taken_i | jump_i) & ~stall;

  // Entry 0 takes the ID instruction only when it actually advances;
  // otherwise a bubble is inserted behind the stalled instruction.
  always_comb begin
    sb_d = '0;
    ex_d = '0;
    if (id_valid_i && !stall) begin
      sb_d[0].valid    = 1'b1;
      sb_d[0].rd       = id_rd_ext;
      sb_d[0].regwrite = id_regwrite_i;
      sb_d[0].memread  = id_memread_i;
      ex_d.rs          = id_rs_ext;
      ex_d.rt          = id_rt_ext;
      ex_d.rs_used     = id_rs_used_i;
      ex_d.rt_used     = id_rt_used_i;
    end
    for (int k = 1; k < STAGES; k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_q <= '0;
      ex_q <= '0;
    end else begin
      sb_q <= sb_d;
      ex_q <= ex_d;
    end
  end

  hazard_fwd_pick #(
    .STAGES   (STAGES),
    .LOAD_LAT (LOAD_LAT),
    .SEL_W    (SEL_W)
  ) u_pick_rs (
    .ex_valid_i (sb_q[0].valid),
    .src_i      (ex_q.rs),
    .src_used_i (ex_q.rs_used),
    .sb_i       (sb_q[STAGES-1:1]),
    .sel_o      (rs_sel)
  );

  hazard_fwd_pick #(
    .STAGES   (STAGES),
    .LOAD_LAT (LOAD_LAT),
    .SEL_W    (SEL_W)
  ) u_pick_rt (
    .ex_valid_i (sb_q[0].valid),
    .src_i      (ex_q.rt),
    .src_used_i (ex_q.rt_used),
    .sb_i       (sb_q[STAGES-1:1]),
    .sel_o      (rt_sel)
  );

  assign stall_o      = stall;
  assign bubble_o     = stall;
  assign flush_ifid_o = flush;
  assign fwd_rs_sel_o = rst_i ? '0 : rs_sel;
  assign fwd_rt_sel_o = rst_i ? '0 : rt_sel;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Free-running event counters; they wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(stall);
    flush_cnt_d = flush_cnt_q + 32'(flush);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
